mac_array_feeder: RTL and testbench

//  Producer side of the MAC-array chained-FIFO input interface. Accepts weight,

---
 rtl/mac_array_feeder_pkg.sv | 15 +
 rtl/mac_array_feeder.sv | 158 +++++++++++++++
 tb/tb_mac_array_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_array_feeder_pkg.sv
// Shared types and lane widths for the MAC-array input feeder.
package mac_array_feeder_pkg;

  // Lane widths of the array's chained-FIFO inputs.
  localparam int DATA_W  = 16;
  localparam int ACCUM_W = 32;

  // Job sequencing: wait for start, stream weights and pairs, report completion.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mac_array_feeder.sv
// Producer side of the MAC-array chained-FIFO input interface. Loads IC0
// weight rows, then streams num_vec ifmap/accum_in pairs, keeping every pair
// strictly behind the weight row it depends on.
//
// Handshakes: on every input stream a transfer ("fire") happens in a cycle
// where both valid and ready are high at the rising edge; ready never depends
// on valid, and the upstream may drop valid at any time. The array side has
// no backpressure: a fire in cycle c yields enq=1 with the captured data in
// cycle c+1.
module mac_array_feeder
  import mac_array_feeder_pkg::*;
#(
  parameter int IC0   = 2,
  parameter int OC0   = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_vec,
  output logic                    busy,
  output logic                    done,
  input  logic                    weight_valid,
  output logic                    weight_ready,
  input  logic [DATA_W*OC0-1:0]   weight_data,
  input  logic                    ifmap_valid,
  output logic                    ifmap_ready,
  input  logic [DATA_W*IC0-1:0]   ifmap_data,
  input  logic                    accum_valid,
  output logic                    accum_ready,
  input  logic [ACCUM_W*OC0-1:0]  accum_data,
  output logic                    en,
  output logic                    en_weight00,
  output logic                    weight_fifo_enq,
  output logic [DATA_W*OC0-1:0]   weight_dat_chained_fifo_in,
  output logic                    ifmap_fifo_enq,
  output logic [DATA_W*IC0-1:0]   ifmap_dat_chained_fifo_in,
  output logic                    accum_in_fifo_enq,
  output logic [ACCUM_W*OC0-1:0]  accum_in_chained_fifo_in,
  output state_e                  dbg_state
);

  localparam int              WC_W   = $clog2(IC0 + 1);
  localparam logic [WC_W-1:0] W_ROWS = WC_W'(IC0);

  state_e                 state_q, state_d;
  logic [WC_W-1:0]        w_cnt_q, w_cnt_d;
  logic [CNT_W-1:0]       p_cnt_q, p_cnt_d;
  logic [CNT_W-1:0]       num_vec_q, num_vec_d;

  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   en_q, en_d;
  logic                   en_w00_q, en_w00_d;
  logic                   w_enq_q, w_enq_d;
  logic                   p_enq_q, p_enq_d;
  logic [DATA_W*OC0-1:0]  w_dat_q, w_dat_d;
  logic [DATA_W*IC0-1:0]  i_dat_q, i_dat_d;
  logic [ACCUM_W*OC0-1:0] a_dat_q, a_dat_d;

  logic run, w_all, gate, w_rdy, p_rdy, w_fire, p_fire;

  // Handshake decode, FSM next state, counters and registered array outputs.
  always_comb begin
    state_d   = state_q;
    w_cnt_d   = w_cnt_q;
    p_cnt_d   = p_cnt_q;
    num_vec_d = num_vec_q;

    run    = (state_q == ST_RUN);
    w_all  = (w_cnt_q == W_ROWS);
    // A pair may only use weight rows already registered at cycle start, so
    // it can never issue alongside the weight fire that would unlock it.
    gate   = w_all || (p_cnt_q < CNT_W'(w_cnt_q));
    w_rdy  = run && !w_all;
    p_rdy  = run && (p_cnt_q < num_vec_q) && gate;
    w_fire = w_rdy && weight_valid;
    p_fire = p_rdy && ifmap_valid && accum_valid;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          num_vec_d = num_vec;
          w_cnt_d   = '0;
          p_cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (w_fire) w_cnt_d = w_cnt_q + WC_W'(1);
        if (p_fire) p_cnt_d = p_cnt_q + CNT_W'(1);
        // Checked on registered counts: the last enq is out before DONE.
        if (w_all && (p_cnt_q == num_vec_q)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d   = (state_d != ST_IDLE);
    en_d     = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    w_enq_d  = w_fire;
    en_w00_d = w_fire && (w_cnt_q == '0);
    p_enq_d  = p_fire;
    w_dat_d  = w_fire ? weight_data : w_dat_q;
    i_dat_d  = p_fire ? ifmap_data  : i_dat_q;
    a_dat_d  = p_fire ? accum_data  : a_dat_q;
  end

  // State, counters and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      w_cnt_q   <= '0;
      p_cnt_q   <= '0;
      num_vec_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      en_w00_q  <= 1'b0;
      w_enq_q   <= 1'b0;
      p_enq_q   <= 1'b0;
      w_dat_q   <= '0;
      i_dat_q   <= '0;
      a_dat_q   <= '0;
    end else begin
      state_q   <= state_d;
      w_cnt_q   <= w_cnt_d;
      p_cnt_q   <= p_cnt_d;
      num_vec_q <= num_vec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      en_q      <= en_d;
      en_w00_q  <= en_w00_d;
      w_enq_q   <= w_enq_d;
      p_enq_q   <= p_enq_d;
      w_dat_q   <= w_dat_d;
      i_dat_q   <= i_dat_d;
      a_dat_q   <= a_dat_d;
    end
  end

  assign busy                       = busy_q;
  assign done                       = done_q;
  assign weight_ready               = w_rdy;
  assign ifmap_ready                = p_rdy;
  assign accum_ready                = p_rdy;
  assign en                         = en_q;
  assign en_weight00                = en_w00_q;
  assign weight_fifo_enq            = w_enq_q;
  assign weight_dat_chained_fifo_in = w_dat_q;
  assign ifmap_fifo_enq             = p_enq_q;
  assign ifmap_dat_chained_fifo_in  = i_dat_q;
  assign accum_in_fifo_enq          = p_enq_q;
  assign accum_in_chained_fifo_in   = a_dat_q;
  assign dbg_state                  = state_q;

endmodule

// File: tb/tb_mac_array_feeder.sv
// Bench for mac_array_feeder: directed scenarios plus randomized jobs, all
// checked against a transaction-level model of the feeder's contract.
module tb_mac_array_feeder;
  import mac_array_feeder_pkg::*;

  localparam int IC0   = 2;
  localparam int OC0   = 2;
  localparam int CNT_W = 16;
  localparam int WD    = DATA_W * OC0;
  localparam int ID    = DATA_W * IC0;
  localparam int AD    = ACCUM_W * OC0;
  localparam int MAXV  = 32;

  logic             clk, rst_n, start;
  logic [CNT_W-1:0] num_vec;
  logic             busy, done;
  logic             weight_valid, weight_ready;
  logic [WD-1:0]    weight_data;
  logic             ifmap_valid, ifmap_ready;
  logic [ID-1:0]    ifmap_data;
  logic             accum_valid, accum_ready;
  logic [AD-1:0]    accum_data;
  logic             en, en_weight00;
  logic             weight_fifo_enq, ifmap_fifo_enq, accum_in_fifo_enq;
  logic [WD-1:0]    weight_dat_chained_fifo_in;
  logic [ID-1:0]    ifmap_dat_chained_fifo_in;
  logic [AD-1:0]    accum_in_chained_fifo_in;
  state_e           dbg_state;

  mac_array_feeder #(.IC0(IC0), .OC0(OC0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .busy(busy), .done(done),
    .weight_valid(weight_valid), .weight_ready(weight_ready), .weight_data(weight_data),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
    .accum_valid(accum_valid), .accum_ready(accum_ready), .accum_data(accum_data),
    .en(en), .en_weight00(en_weight00),
    .weight_fifo_enq(weight_fifo_enq), .weight_dat_chained_fifo_in(weight_dat_chained_fifo_in),
    .ifmap_fifo_enq(ifmap_fifo_enq), .ifmap_dat_chained_fifo_in(ifmap_dat_chained_fifo_in),
    .accum_in_fifo_enq(accum_in_fifo_enq), .accum_in_chained_fifo_in(accum_in_chained_fifo_in),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus data ----------------
  logic [WD-1:0] w_rows [IC0];
  logic [ID-1:0] if_vec [MAXV];
  logic [AD-1:0] ac_vec [MAXV];
  int  n_items;
  bit  drv_on, rand_mode;
  int  w_gap_at, w_gap_left, a_gap_at, a_gap_left;

  // ---------------- model state ----------------
  bit  mon_on, job_active, start_pend, done_due;
  bit  idle_m, run_m, exp_done, exp_wr, exp_pr, w_ex, p_ex;
  int  n_job, w_acc, p_acc, w_enq, p_enq, rel, jobs_done, done_cyc, p_at_w1;
  int  w_enq_cyc [IC0];
  int  p_enq_cyc [MAXV];
  logic [WD-1:0] exp_w_q[$];
  logic [ID-1:0] exp_i_q[$];
  logic [AD-1:0] exp_a_q[$];
  logic [WD-1:0] last_w;
  logic [ID-1:0] last_i;
  logic [AD-1:0] last_a;

  // ---------------- driver ----------------
  bit w_ok, i_ok, a_ok;
  always @(posedge clk) begin
    #1;
    w_ok = (!rand_mode || $urandom_range(0, 3) != 0);
    i_ok = (!rand_mode || $urandom_range(0, 3) != 0);
    a_ok = (!rand_mode || $urandom_range(0, 3) != 0);
    if (job_active && w_acc == w_gap_at && w_gap_left > 0) begin
      w_ok = 1'b0;
      w_gap_left--;
    end
    if (job_active && p_acc == a_gap_at && a_gap_left > 0) begin
      a_ok = 1'b0;
      a_gap_left--;
    end
    if (w_acc < IC0) weight_data = w_rows[w_acc];
    if (p_acc < MAXV) begin
      ifmap_data = if_vec[p_acc];
      accum_data = ac_vec[p_acc];
    end
    weight_valid = drv_on && (w_acc < IC0) && w_ok;
    ifmap_valid  = drv_on && (p_acc < n_items) && i_ok;
    accum_valid  = drv_on && (p_acc < n_items) && a_ok;
  end

  // ---------------- monitor + scoreboard ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      idle_m = !job_active && !start_pend;
      if (start_pend) begin
        job_active = 1'b1;
        start_pend = 1'b0;
        rel = 0;
      end else if (job_active) begin
        rel++;
      end
      run_m    = job_active && !done_due;
      exp_done = job_active && done_due;
      check_eq("busy", 64'(busy), 64'(job_active));
      check_eq("en", 64'(en), 64'(job_active));
      check_eq("done", 64'(done), 64'(exp_done));

      exp_wr = run_m && (w_acc < IC0);
      exp_pr = run_m && (p_acc < n_job) && (w_acc == IC0 || p_acc < w_acc);
      check_eq("weight_ready", 64'(weight_ready), 64'(exp_wr));
      check_eq("ifmap_ready", 64'(ifmap_ready), 64'(exp_pr));
      check_eq("accum_ready", 64'(accum_ready), 64'(exp_pr));

      w_ex = (exp_w_q.size() > 0);
      check_eq("weight_enq", 64'(weight_fifo_enq), 64'(w_ex));
      if (w_ex) begin
        last_w = exp_w_q.pop_front();
        check_eq("en_weight00", 64'(en_weight00), 64'(w_enq == 0));
        if (w_enq < IC0) w_enq_cyc[w_enq] = rel;
        w_enq++;
        if (w_enq == IC0) p_at_w1 = p_enq;
      end else begin
        check_eq("en_weight00_idle", 64'(en_weight00), 64'(0));
      end
      check_eq("weight_dat", 64'(weight_dat_chained_fifo_in), 64'(last_w));

      p_ex = (exp_i_q.size() > 0);
      check_eq("ifmap_enq", 64'(ifmap_fifo_enq), 64'(p_ex));
      check_eq("accum_enq", 64'(accum_in_fifo_enq), 64'(p_ex));
      if (p_ex) begin
        last_i = exp_i_q.pop_front();
        last_a = exp_a_q.pop_front();
        if (p_enq < MAXV) p_enq_cyc[p_enq] = rel;
        p_enq++;
      end
      check_eq("ifmap_dat", 64'(ifmap_dat_chained_fifo_in), 64'(last_i));
      check_eq("accum_dat", accum_in_chained_fifo_in, last_a);

      if (job_active && !done_due && w_enq == IC0 && p_enq == n_job) begin
        done_due = 1'b1;
      end else if (exp_done) begin
        done_cyc   = rel;
        job_active = 1'b0;
        done_due   = 1'b0;
        jobs_done++;
      end

      if (rst_n) begin
        if (weight_valid && weight_ready) begin
          exp_w_q.push_back(weight_data);
          w_acc++;
        end
        if (ifmap_valid && accum_valid && ifmap_ready && accum_ready) begin
          exp_i_q.push_back(ifmap_data);
          exp_a_q.push_back(accum_data);
          p_acc++;
        end
        if (start && idle_m) begin
          start_pend = 1'b1;
          n_job = int'(num_vec);
          w_acc = 0; p_acc = 0; w_enq = 0; p_enq = 0;
        end
      end else begin
        exp_w_q.delete(); exp_i_q.delete(); exp_a_q.delete();
        job_active = 1'b0; start_pend = 1'b0; done_due = 1'b0;
        w_acc = 0; p_acc = 0; w_enq = 0; p_enq = 0;
        last_w = '0; last_i = '0; last_a = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_directed();
    w_rows[0] = {16'd2, 16'd1};
    w_rows[1] = {16'd4, 16'd3};
    for (int k = 0; k < 4; k++) begin
      if_vec[k] = {16'(9 + k), 16'(5 + k)};
      ac_vec[k] = {32'(k + 1), 32'(-(k + 1))};
    end
  endtask

  task automatic load_random();
    for (int k = 0; k < IC0; k++) w_rows[k] = WD'($urandom);
    for (int k = 0; k < MAXV; k++) begin
      if_vec[k] = ID'($urandom);
      ac_vec[k] = {32'($urandom), 32'($urandom)};
    end
  endtask

  task automatic run_job(input int n, input bit rnd, input bit pulse_mid);
    int t0;
    t0 = jobs_done;
    rand_mode = rnd;
    n_items = n;
    @(posedge clk); #1;
    start = 1'b1;
    num_vec = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    num_vec = CNT_W'($urandom);
    if (pulse_mid) begin
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      num_vec = CNT_W'(7);
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 400 && jobs_done == t0; i++) @(posedge clk);
    if (jobs_done == t0) check_eq("job_timeout", 64'(0), 64'(1));
    @(posedge clk);
  endtask

  task automatic check_scenario1(input string tag);
    check_eq({tag, "_w0_cyc"}, 64'(w_enq_cyc[0]), 64'(1));
    check_eq({tag, "_w1_cyc"}, 64'(w_enq_cyc[1]), 64'(2));
    check_eq({tag, "_p0_cyc"}, 64'(p_enq_cyc[0]), 64'(2));
    check_eq({tag, "_p3_cyc"}, 64'(p_enq_cyc[3]), 64'(5));
    check_eq({tag, "_done_cyc"}, 64'(done_cyc), 64'(6));
    check_eq({tag, "_pairs"}, 64'(p_enq), 64'(4));
  endtask

  // ---------------- main sequence ----------------
  int jobs_before;
  initial begin
    rst_n = 1'b0; start = 1'b0; num_vec = '0;
    weight_valid = 1'b0; ifmap_valid = 1'b0; accum_valid = 1'b0;
    weight_data = '0; ifmap_data = '0; accum_data = '0;
    drv_on = 1'b0; rand_mode = 1'b0; n_items = 0;
    w_gap_at = -1; w_gap_left = 0; a_gap_at = -1; a_gap_left = 0;
    last_w = '0; last_i = '0; last_a = '0;
    load_directed();
    repeat (2) @(posedge clk);
    #1 mon_on = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drv_on = 1'b1;

    // 1: nominal stream, all valids high
    run_job(4, 1'b0, 1'b0);
    check_scenario1("s1");

    // 2: weight row 1 delayed three cycles
    w_gap_at = 1; w_gap_left = 3;
    run_job(4, 1'b0, 1'b0);
    check_eq("s2_pairs_before_w1", 64'(p_at_w1), 64'(1));
    check_eq("s2_w1_cyc", 64'(w_enq_cyc[1]), 64'(5));
    check_eq("s2_p0_cyc", 64'(p_enq_cyc[0]), 64'(2));
    check_eq("s2_p1_cyc", 64'(p_enq_cyc[1]), 64'(6));
    w_gap_at = -1;

    // 3: accum_in gap of two cycles mid-stream
    a_gap_at = 2; a_gap_left = 2;
    run_job(4, 1'b0, 1'b0);
    check_eq("s3_p2_gap", 64'(p_enq_cyc[2] - p_enq_cyc[1]), 64'(3));
    check_eq("s3_pairs", 64'(p_enq), 64'(4));
    a_gap_at = -1;

    // 4: weights only
    run_job(0, 1'b0, 1'b0);
    check_eq("s4_w_enqs", 64'(w_enq), 64'(IC0));
    check_eq("s4_p_enqs", 64'(p_enq), 64'(0));
    check_eq("s4_done_cyc", 64'(done_cyc), 64'(w_enq_cyc[1] + 1));

    // 5: reset while P1 is being enqueued, then replay
    jobs_before = jobs_done;
    n_items = 4; rand_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; num_vec = CNT_W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (ifmap_fifo_enq === 1'b1 && p_enq == 1) break;
    end
    check_eq("s5_p1_enq_seen", 64'(ifmap_fifo_enq), 64'(1));
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    check_eq("s5_outputs_zero",
             64'({en, busy, done, en_weight00, weight_fifo_enq, ifmap_fifo_enq, accum_in_fifo_enq}),
             64'(0));
    check_eq("s5_wdat_zero", 64'(weight_dat_chained_fifo_in), 64'(0));
    repeat (3) @(posedge clk);
    check_eq("s5_no_done", 64'(jobs_done), 64'(jobs_before));
    run_job(4, 1'b0, 1'b0);
    check_scenario1("s5_replay");

    // 6: start pulsed while busy is ignored
    run_job(4, 1'b0, 1'b1);
    check_scenario1("s6");

    // randomized jobs with random valid stalls
    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(0, 9);
      load_random();
      run_job(n, 1'b1, (j % 3) == 1);
      check_eq("rnd_w_enqs", 64'(w_enq), 64'(IC0));
      check_eq("rnd_p_enqs", 64'(p_enq), 64'(n));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
